// File: rtl/persiana_niveles.sv
// persiana_niveles: multi-level blind controller.
// Drives the motor pair (subir/bajar) so the blind reaches a requested level out of NIVELES
// positions. Each position has its own sensor. After reset the blind homes to level 0. Every
// stop is followed by a motor dead time. A move that outlasts TIMEOUT cycles latches a fault,
// and only reset clears that fault.
//
// Ports:
//   reloj         system clock, rising edge
//   reset         synchronous, active-high reset
//   P             requested target level; values >= NIVELES are ignored
//   sensores      one-hot-ish position sensors, sensores[i]=1 at level i
//   subir, bajar  registered motor commands, never both high
//   nivel_actual  registered last confirmed level
//   ocupado       high whenever the controller is not idle
//   falla         latched timeout fault
//
// Optional feature: define PERSIANA_RETARGET_EN to let P retarget a move in progress.
module persiana_niveles #(
  parameter int unsigned NIVELES = 4,
  parameter int unsigned ANCHO   = $clog2(NIVELES),
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned MUERTO  = 8
) (
  input  logic               reloj,
  input  logic               reset,
  input  logic [ANCHO-1:0]   P,
  input  logic [NIVELES-1:0] sensores,
  output logic               subir,
  output logic               bajar,
  output logic [ANCHO-1:0]   nivel_actual,
  output logic               ocupado,
  output logic               falla
);

  // One counter serves both the motion timeout and the dead time.
  localparam int unsigned TMAX = (TIMEOUT > MUERTO) ? TIMEOUT : MUERTO;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TimeoutFin = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] MuertoFin  = TW'(MUERTO - 1);

  typedef enum logic [2:0] {
    StHoming,
    StReposo,
    StSubiendo,
    StBajando,
    StPausa,
    StFalla
  } estado_e;

  estado_e          estado_q, estado_d;
  logic             subir_q, subir_d;
  logic             bajar_q, bajar_d;
  logic             falla_q, falla_d;
  logic [ANCHO-1:0] nivel_q, nivel_d;
  logic [ANCHO-1:0] objetivo_q, objetivo_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             p_valido;
  logic             sens_hay;
  logic [ANCHO-1:0] sens_idx;

  assign p_valido = (32'(P) < NIVELES);

  // Lowest asserted sensor wins when several are set.
  always_comb begin
    sens_hay = 1'b0;
    sens_idx = '0;
    for (int i = NIVELES - 1; i >= 0; i--) begin
      if (sensores[i]) begin
        sens_hay = 1'b1;
        sens_idx = ANCHO'(i);
      end
    end
  end

  always_comb begin
    estado_d   = estado_q;
    subir_d    = 1'b0;
    bajar_d    = 1'b0;
    nivel_d    = nivel_q;
    objetivo_d = objetivo_q;
    falla_d    = falla_q;
    timer_d    = timer_q;
    case (estado_q)
      StHoming: begin
        if (sensores[0]) begin
          nivel_d  = '0;
          timer_d  = '0;
          estado_d = StPausa;
        end else if (timer_q == TimeoutFin) begin
          falla_d  = 1'b1;
          estado_d = StFalla;
        end else begin
          bajar_d = 1'b1;
          timer_d = timer_q + 1'b1;
        end
      end
      StReposo: begin
        if (p_valido && (P > nivel_q)) begin
          objetivo_d = P;
          subir_d    = 1'b1;
          timer_d    = '0;
          estado_d   = StSubiendo;
        end else if (p_valido && (P < nivel_q)) begin
          objetivo_d = P;
          bajar_d    = 1'b1;
          timer_d    = '0;
          estado_d   = StBajando;
        end
      end
      StSubiendo: begin
        if (sens_hay) nivel_d = sens_idx;
        if (sensores[objetivo_q]) begin
          nivel_d  = objetivo_q;
          timer_d  = '0;
          estado_d = StPausa;
        end else if (timer_q == TimeoutFin) begin
          falla_d  = 1'b1;
          estado_d = StFalla;
        end else begin
          subir_d = 1'b1;
          timer_d = timer_q + 1'b1;
`ifdef PERSIANA_RETARGET_EN
          if (p_valido && (P > nivel_d)) begin
            objetivo_d = P;
          end else if (p_valido) begin
            // Reversal or stop-here request: halt now, resume after the dead time.
            subir_d    = 1'b0;
            objetivo_d = P;
            timer_d    = '0;
            estado_d   = StPausa;
          end
`endif
        end
      end
      StBajando: begin
        if (sens_hay) nivel_d = sens_idx;
        if (sensores[objetivo_q]) begin
          nivel_d  = objetivo_q;
          timer_d  = '0;
          estado_d = StPausa;
        end else if (timer_q == TimeoutFin) begin
          falla_d  = 1'b1;
          estado_d = StFalla;
        end else begin
          bajar_d = 1'b1;
          timer_d = timer_q + 1'b1;
`ifdef PERSIANA_RETARGET_EN
          if (p_valido && (P < nivel_d)) begin
            objetivo_d = P;
          end else if (p_valido) begin
            bajar_d    = 1'b0;
            objetivo_d = P;
            timer_d    = '0;
            estado_d   = StPausa;
          end
`endif
        end
      end
      StPausa: begin
        if (timer_q == MuertoFin) begin
          estado_d = StReposo;
`ifdef PERSIANA_RETARGET_EN
          // Only a retarget leaves objetivo away from the current level.
          timer_d = '0;
          if (objetivo_q > nivel_q) begin
            subir_d  = 1'b1;
            estado_d = StSubiendo;
          end else if (objetivo_q < nivel_q) begin
            bajar_d  = 1'b1;
            estado_d = StBajando;
          end
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFalla: begin
        falla_d = 1'b1;
      end
      default: begin
        estado_d = StHoming;
      end
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q   <= StHoming;
      subir_q    <= 1'b0;
      bajar_q    <= 1'b0;
      nivel_q    <= '0;
      objetivo_q <= '0;
      falla_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      subir_q    <= subir_d;
      bajar_q    <= bajar_d;
      nivel_q    <= nivel_d;
      objetivo_q <= objetivo_d;
      falla_q    <= falla_d;
      timer_q    <= timer_d;
    end
  end

  assign subir        = subir_q;
  assign bajar        = bajar_q;
  assign nivel_actual = nivel_q;
  assign falla        = falla_q;
  assign ocupado      = (estado_q != StReposo);

endmodule

// File: tb/tb_persiana_niveles.sv
// Self-checking bench for persiana_niveles (NIVELES=4, TIMEOUT=100, MUERTO=4), plus a
// NIVELES=3 instance for out-of-range commands. Expected output words are
// {subir, bajar, nivel_actual, ocupado, falla}.
module tb_persiana_niveles;

  logic       reloj = 1'b0;
  logic       reset;
  logic [1:0] P;
  logic [3:0] sensores;
  logic       subir, bajar, ocupado, falla;
  logic [1:0] nivel_actual;

  logic [1:0] p3;
  logic [2:0] s3;
  logic       subir3, bajar3, ocupado3, falla3;
  logic [1:0] nivel3;

  logic [5:0] obs, obs3;
  logic [5:0] exp_q[$];
  logic [5:0] exp3_q[$];
  int checks = 0;
  int errors = 0;

  assign obs  = {subir, bajar, nivel_actual, ocupado, falla};
  assign obs3 = {subir3, bajar3, nivel3, ocupado3, falla3};

  always #5 reloj = ~reloj;

  persiana_niveles #(.NIVELES(4), .TIMEOUT(100), .MUERTO(4)) dut (
    .reloj(reloj), .reset(reset), .P(P), .sensores(sensores), .subir(subir), .bajar(bajar),
    .nivel_actual(nivel_actual), .ocupado(ocupado), .falla(falla)
  );

  persiana_niveles #(.NIVELES(3), .TIMEOUT(100), .MUERTO(4)) dut3 (
    .reloj(reloj), .reset(reset), .P(p3), .sensores(s3), .subir(subir3), .bajar(bajar3),
    .nivel_actual(nivel3), .ocupado(ocupado3), .falla(falla3)
  );

  function automatic logic [5:0] ex(input logic s, input logic b, input logic [1:0] n,
                                    input logic o, input logic f);
    return {s, b, n, o, f};
  endfunction

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // Motor commands must never overlap.
  always @(negedge reloj) begin
    if (reset === 1'b0) begin
      checks++;
      if ((subir & bajar) === 1'b1 || (subir3 & bajar3) === 1'b1) begin
        errors++;
        $display("FAIL motor_excl: subir=%b bajar=%b subir3=%b bajar3=%b, required not both 1",
                 subir, bajar, subir3, bajar3);
      end
    end
  end

  // Reset state, then homing: sensor 0 arrives on the 11th edge; dut3 already sits at level 0.
  task automatic test_reset();
    logic [5:0] e;
    reset = 1'b1; P = 2'd0; sensores = 4'b0000; p3 = 2'd0; s3 = 3'b001;
    tick(); tick();
    exp_q.push_back(ex(0, 0, 0, 1, 0));
    exp3_q.push_back(ex(0, 0, 0, 1, 0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got=%b want=%b", obs, e); end
    e = exp3_q.pop_front(); checks++;
    if (obs3 !== e) begin errors++; $display("FAIL reset3: got=%b want=%b", obs3, e); end
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 11) sensores = 4'b0001;
      exp_q.push_back(k <= 10 ? ex(0, 1, 0, 1, 0) : (k <= 14 ? ex(0, 0, 0, 1, 0)
                                                             : ex(0, 0, 0, 0, 0)));
      exp3_q.push_back(k <= 4 ? ex(0, 0, 0, 1, 0) : ex(0, 0, 0, 0, 0));
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL homing k=%0d: got=%b want=%b", k, obs, e); end
      e = exp3_q.pop_front(); checks++;
      if (obs3 !== e) begin
        errors++; $display("FAIL homing3 k=%0d: got=%b want=%b", k, obs3, e);
      end
    end
  endtask

  // Level 0 -> 3 passing through sensors 1 and 2.
  task automatic test_subir();
    logic [3:0] st [11];
    logic [5:0] et [11];
    logic [5:0] e;
    st = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
           4'b1000, 4'b1000};
    et = '{ex(1,0,0,1,0), ex(1,0,0,1,0), ex(1,0,0,1,0), ex(1,0,1,1,0), ex(1,0,1,1,0),
           ex(1,0,2,1,0), ex(0,0,3,1,0), ex(0,0,3,1,0), ex(0,0,3,1,0), ex(0,0,3,1,0),
           ex(0,0,3,0,0)};
    P = 2'd3;
    for (int k = 0; k < 11; k++) begin
      sensores = st[k];
      exp_q.push_back(et[k]);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL subir k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask

  // Level 3 -> 1; a mid-move P=0 is ignored, then P=1 at level 1 does nothing.
  task automatic test_bajar();
    logic [3:0] st [12];
    logic [5:0] et [12];
    logic [5:0] e;
    st = '{4'b1000, 4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
           4'b0010, 4'b0010, 4'b0010};
    et = '{ex(0,1,3,1,0), ex(0,1,3,1,0), ex(0,1,2,1,0), ex(0,1,2,1,0), ex(0,0,1,1,0),
           ex(0,0,1,1,0), ex(0,0,1,1,0), ex(0,0,1,1,0), ex(0,0,1,0,0), ex(0,0,1,0,0),
           ex(0,0,1,0,0), ex(0,0,1,0,0)};
    P = 2'd1;
    for (int k = 0; k < 12; k++) begin
`ifndef PERSIANA_RETARGET_EN
      if (k == 1) P = 2'd0;
`endif
      if (k == 5) P = 2'd1;
      sensores = st[k];
      exp_q.push_back(et[k]);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL bajar k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask

  // 1 -> 2 then 2 -> 0 issued at once. Motor stays off for the MUERTO pause cycles plus the
  // single idle cycle in which the queued command is sampled.
  task automatic test_back_to_back();
    logic [3:0] st [13];
    logic [5:0] et [13];
    logic [5:0] e;
    st = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0001,
           4'b0001, 4'b0001, 4'b0001, 4'b0001};
    et = '{ex(1,0,1,1,0), ex(0,0,2,1,0), ex(0,0,2,1,0), ex(0,0,2,1,0), ex(0,0,2,1,0),
           ex(0,0,2,0,0), ex(0,1,2,1,0), ex(0,1,1,1,0), ex(0,0,0,1,0), ex(0,0,0,1,0),
           ex(0,0,0,1,0), ex(0,0,0,1,0), ex(0,0,0,0,0)};
    P = 2'd2;
    for (int k = 0; k < 13; k++) begin
      if (k == 2) P = 2'd0;
      sensores = st[k];
      exp_q.push_back(et[k]);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask

  // NIVELES=3: P=3 is out of range and ignored; P=2 then starts a move.
  task automatic test_nivel_invalido();
    logic [5:0] e;
    p3 = 2'd3;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) p3 = 2'd2;
      exp3_q.push_back(k < 5 ? ex(0, 0, 0, 0, 0) : ex(1, 0, 0, 1, 0));
      exp_q.push_back(ex(0, 0, 0, 0, 0));
      tick();
      e = exp3_q.pop_front(); checks++;
      if (obs3 !== e) begin
        errors++; $display("FAIL invalido3 k=%0d: got=%b want=%b", k, obs3, e);
      end
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL idle k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask

  // P=2 with sensors stuck at level 0: 100 cycles of subir, then latched fault until reset.
  task automatic test_timeout();
    logic [5:0] e;
    P = 2'd2; sensores = 4'b0001;
    for (int k = 1; k <= 110; k++) begin
      exp_q.push_back(k <= 100 ? ex(1, 0, 0, 1, 0) : ex(0, 0, 0, 1, 1));
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout k=%0d: got=%b want=%b", k, obs, e); end
    end
    P = 2'd0; reset = 1'b1;
    exp_q.push_back(ex(0, 0, 0, 1, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL falla_clear: got=%b want=%b", obs, e); end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(k <= 4 ? ex(0, 0, 0, 1, 0) : ex(0, 0, 0, 0, 0));
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rehome k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask

  // Reset during an up move drops the motor on the reset edge.
  task automatic test_reset_movimiento();
    logic [5:0] e;
    P = 2'd2;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin reset = 1'b1; P = 2'd0; end
      exp_q.push_back(k < 2 ? ex(1, 0, 0, 1, 0) : ex(0, 0, 0, 1, 0));
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_mov k=%0d: got=%b want=%b", k, obs, e); end
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL rst_mov_idle: got=%b want=%b", obs, ex(0, 0, 0, 0, 0));
    end
  endtask

`ifdef PERSIANA_RETARGET_EN
  // Up 0 -> 3, P=1 once at level 2: immediate stop, 4 idle cycles, then down to level 1.
  task automatic test_retarget();
    logic [3:0] st [14];
    logic [5:0] et [14];
    logic [5:0] e;
    st = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    et = '{ex(1,0,0,1,0), ex(1,0,1,1,0), ex(1,0,2,1,0), ex(0,0,2,1,0), ex(0,0,2,1,0),
           ex(0,0,2,1,0), ex(0,0,2,1,0), ex(0,1,2,1,0), ex(0,1,2,1,0), ex(0,0,1,1,0),
           ex(0,0,1,1,0), ex(0,0,1,1,0), ex(0,0,1,1,0), ex(0,0,1,0,0)};
    P = 2'd3;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) P = 2'd1;
      sensores = st[k];
      exp_q.push_back(et[k]);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL retarget k=%0d: got=%b want=%b", k, obs, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_subir();
    test_bajar();
    test_back_to_back();
    test_nivel_invalido();
    test_timeout();
    test_reset_movimiento();
`ifdef PERSIANA_RETARGET_EN
    test_retarget();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
